// File: rtl/imm_decode_stage.sv
// Registered MIPS immediate-decode stage with a two-entry (output + skid) valid/ready buffer.
// Selects and extends the 16-bit immediate; never shifts (LUI shifting happens downstream).
module imm_decode_stage #(
  parameter logic [31:0] RESET_IMM = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] in_instr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  opcode,
  output logic [1:0]  imm_kind,
  output logic [31:0] imm_out,
  output logic [4:0]  dest_reg,
  output logic        reg_write
);

  localparam logic [1:0] KindNone  = 2'd0;
  localparam logic [1:0] KindSign  = 2'd1;
  localparam logic [1:0] KindZero  = 2'd2;
  localparam logic [1:0] KindUpper = 2'd3;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [1:0]  imm_kind;
    logic [31:0] imm;
    logic [4:0]  dest_reg;
    logic        reg_write;
  } entry_t;

  localparam entry_t ResetEntry = '{
    opcode:    6'd0,
    imm_kind:  KindNone,
    imm:       RESET_IMM,
    dest_reg:  5'd0,
    reg_write: 1'b0
  };

  entry_t dec;
  entry_t out_d, out_q, skid_d, skid_q;
  logic   out_valid_d, out_valid_q, skid_valid_d, skid_valid_q;
  logic   accept, drain;
  logic   unused_rs;

  // rs is consumed by the execute stage, not here
  assign unused_rs = ^in_instr[25:21];

  always_comb begin
    dec        = '0;
    dec.opcode = in_instr[31:26];
    case (in_instr[31:26])
      6'h00: begin
        dec.dest_reg  = in_instr[15:11];
        dec.reg_write = 1'b1;
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h23: begin
        dec.imm_kind  = KindSign;
        dec.imm       = {{16{in_instr[15]}}, in_instr[15:0]};
        dec.dest_reg  = in_instr[20:16];
        dec.reg_write = 1'b1;
      end
      6'h0c, 6'h0d, 6'h0e: begin
        dec.imm_kind  = KindZero;
        dec.imm       = {16'h0000, in_instr[15:0]};
        dec.dest_reg  = in_instr[20:16];
        dec.reg_write = 1'b1;
      end
      6'h0f: begin
        dec.imm_kind  = KindUpper;
        dec.imm       = {16'h0000, in_instr[15:0]};
        dec.dest_reg  = in_instr[20:16];
        dec.reg_write = 1'b1;
      end
      6'h2b, 6'h04, 6'h05: begin
        dec.imm_kind = KindSign;
        dec.imm      = {{16{in_instr[15]}}, in_instr[15:0]};
      end
      default: ;
    endcase
  end

  assign accept = in_valid & ~skid_valid_q;
  assign drain  = out_valid_q & out_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_d        = ResetEntry;
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || drain) begin
      // Output slot frees up: refill from skid first to preserve order
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= ResetEntry;
      skid_q       <= ResetEntry;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = out_valid_q;
  assign opcode    = out_q.opcode;
  assign imm_kind  = out_q.imm_kind;
  assign imm_out   = out_q.imm;
  assign dest_reg  = out_q.dest_reg;
  assign reg_write = out_q.reg_write;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: directed cases from the decode table plus randomized
// traffic with back-pressure, flushes and an asynchronous reset mid-stream.
module tb_imm_decode_stage;

  localparam logic [31:0] RstImm = 32'hA5A5_5A5A;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [1:0]  kind;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        rw;
  } exp_t;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, reg_write;
  logic [31:0] in_instr, imm_out;
  logic [5:0]  opcode;
  logic [1:0]  imm_kind;
  logic [4:0]  dest_reg;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  imm_decode_stage #(.RESET_IMM(RstImm)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_instr (in_instr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .opcode   (opcode),
    .imm_kind (imm_kind),
    .imm_out  (imm_out),
    .dest_reg (dest_reg),
    .reg_write(reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference decode straight from the opcode table
  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t e;
    int unsigned op, lo16, sext;
    op   = ins >> 26;
    lo16 = ins & 32'hFFFF;
    sext = (lo16 >= 32'h8000) ? lo16 + 32'hFFFF_0000 : lo16;
    e.opcode = 6'(op);
    e.kind = 2'd0; e.imm = 32'd0; e.dest = 5'd0; e.rw = 1'b0;
    if (op == 0) begin
      e.dest = 5'((ins >> 11) & 31); e.rw = 1'b1;
    end else if (op inside {8, 9, 10, 11, 35}) begin
      e.kind = 2'd1; e.imm = sext; e.dest = 5'((ins >> 16) & 31); e.rw = 1'b1;
    end else if (op inside {12, 13, 14}) begin
      e.kind = 2'd2; e.imm = lo16; e.dest = 5'((ins >> 16) & 31); e.rw = 1'b1;
    end else if (op == 15) begin
      e.kind = 2'd3; e.imm = lo16; e.dest = 5'((ins >> 16) & 31); e.rw = 1'b1;
    end else if (op inside {43, 4, 5}) begin
      e.kind = 2'd1; e.imm = sext;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0]  op;
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 13))
      0: op = 6'h00;  1: op = 6'h08;  2: op = 6'h09;  3: op = 6'h0a;
      4: op = 6'h0b;  5: op = 6'h0c;  6: op = 6'h0d;  7: op = 6'h0e;
      8: op = 6'h0f;  9: op = 6'h23;  10: op = 6'h2b; 11: op = 6'h04;
      12: op = 6'h05; default: op = 6'($urandom);
    endcase
    return {op, r[25:0]};
  endfunction

  // Output monitor: model occupancy decides out_valid/in_ready; front of queue gives the data
  always @(negedge clk) begin
    if (rst_n) begin
      check("mon_in_ready", 32'(in_ready), 32'(q.size() < 2));
      check("mon_out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0 && out_valid) begin
        check("mon_opcode", 32'(opcode), 32'(q[0].opcode));
        check("mon_imm_kind", 32'(imm_kind), 32'(q[0].kind));
        check("mon_imm_out", imm_out, q[0].imm);
        check("mon_dest_reg", 32'(dest_reg), 32'(q[0].dest));
        check("mon_reg_write", 32'(reg_write), 32'(q[0].rw));
      end
      if (flush) q.delete();
      else if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
    end
  end

  // Drive one cycle; an accepted instruction has its expected decode pushed
  task automatic drive(input logic v, input logic [31:0] ins, input logic ordy, input logic fl,
                       output logic acc);
    @(posedge clk);
    #1;
    in_valid = v; in_instr = ins; out_ready = ordy; flush = fl;
    #7;
    acc = rst_n && v && in_ready && !fl;
    if (acc) q.push_back(ref_decode(ins));
  endtask

  task automatic send(input logic [31:0] ins, input logic ordy);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) drive(1'b1, ins, ordy, 1'b0, acc);
    check("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) drive(1'b0, $urandom, ordy, 1'b0, acc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_imm_out"}, imm_out, RstImm);
    check({tag, "_opcode"}, 32'(opcode), 32'd0);
    check({tag, "_imm_kind"}, 32'(imm_kind), 32'd0);
    check({tag, "_dest_reg"}, 32'(dest_reg), 32'd0);
    check({tag, "_reg_write"}, 32'(reg_write), 32'd0);
  endtask

  initial begin
    logic acc;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    #1 rst_n = 1'b1;

    // Directed decode cases
    send(32'h3C01_1234, 1'b1);
    send(32'h2002_FFFF, 1'b1);
    send(32'h3443_8000, 1'b1);
    send(32'hAC05_0004, 1'b1);
    send(32'h0022_2020, 1'b1);
    send(32'h7C00_FFFF, 1'b1);
    idle(3, 1'b1);

    // Back-pressure: two entries fit, third waits until release
    send(32'h2004_0011, 1'b0);
    send(32'h3405_8001, 1'b0);
    drive(1'b1, 32'h8C06_FFF0, 1'b0, 1'b0, acc);
    check("bp_third_blocked", 32'(acc), 32'd0);
    send(32'h8C06_FFF0, 1'b1);
    idle(4, 1'b1);

    // Flush with both entries full and an input presented
    send(32'h2007_0001, 1'b0);
    send(32'h2008_0002, 1'b0);
    drive(1'b1, 32'h2009_0003, 1'b0, 1'b1, acc);
    #3;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_imm_out", imm_out, RstImm);
    flush = 1'b0; in_valid = 1'b0;
    idle(3, 1'b1);

    // Randomized traffic: first half light back-pressure, second half heavy
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, rand_instr(),
            ($urandom % 4) < ((i < 200) ? 3 : 1), ($urandom % 40) == 0, acc);
    end
    flush = 1'b0;
    idle(4, 1'b1);
    check("drain_empty", 32'(q.size()), 32'd0);

    // Asynchronous reset between edges with buffered entries
    send(32'h200A_1111, 1'b0);
    send(32'h200B_2222, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    send(32'h3C01_1234, 1'b1);
    send(32'h8C45_FFF0, 1'b1);
    idle(4, 1'b1);
    check("final_drain", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
